// File: rtl/mesh_resource_ni_pkg.sv
// Packet layout and status-bit definitions shared by the mesh switch and its resource network interface.
// The packet is {x, y, data}, with X in the MSBs.
package mesh_resource_ni_pkg;

    localparam int PCKT_XADDR_W_DEF = 4;
    localparam int PCKT_YADDR_W_DEF = 4;
    localparam int PCKT_DATA_W_DEF  = 8;
    localparam int FIFO_DEPTH_W_DEF = 2;
    localparam int CNT_W_DEF        = 16;

    // Bit positions inside the sticky err_o vector
    localparam int ERR_OVERFLOW_BIT = 0;
    localparam int ERR_MISROUTE_BIT = 1;

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock fall-through FIFO with a synchronous active-high reset.
// Writes are accepted when not full, or when a read happens in the same cycle.
module ni_sync_fifo #(
    parameter int W       = 8,
    parameter int DEPTH_W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << DEPTH_W;

    // Extra pointer MSB tells full apart from empty when the index bits match
    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;
    logic [W-1:0]     mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                       (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
    assign do_rd     = rd_en_i & ~empty_o;
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign rd_data_o = mem[rd_ptr[DEPTH_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[DEPTH_W-1:0]] <= wr_data_i;
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesh_resource_ni.sv
// Network interface between a processing element and the resource port of an XY mesh switch.
// TX packs and injects packets under the switch FIFO full flag; RX checks the address and delivers payloads.
module mesh_resource_ni
    import mesh_resource_ni_pkg::*;
#(
    parameter int X_CORD       = 0,
    parameter int Y_CORD       = 0,
    parameter int PCKT_XADDR_W = PCKT_XADDR_W_DEF,
    parameter int PCKT_YADDR_W = PCKT_YADDR_W_DEF,
    parameter int PCKT_DATA_W  = PCKT_DATA_W_DEF,
    parameter int FIFO_DEPTH_W = FIFO_DEPTH_W_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  tx_valid_i,
    output logic                                                  tx_ready_o,
    input  logic [PCKT_XADDR_W-1:0]                               tx_dst_x_i,
    input  logic [PCKT_YADDR_W-1:0]                               tx_dst_y_i,
    input  logic [PCKT_DATA_W-1:0]                                tx_data_i,
    input  logic                                                  sw_full_i,
    output logic                                                  sw_wr_en_o,
    output logic [PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W-1:0]      sw_pckt_o,
    input  logic                                                  sw_wr_en_i,
    input  logic [PCKT_XADDR_W+PCKT_YADDR_W+PCKT_DATA_W-1:0]      sw_pckt_i,
    output logic                                                  rx_full_o,
    output logic                                                  rx_valid_o,
    input  logic                                                  rx_ready_i,
    output logic [PCKT_DATA_W-1:0]                                rx_data_o,
    output logic [1:0]                                            err_o,
    output logic [CNT_W-1:0]                                      tx_cnt_o,
    output logic [CNT_W-1:0]                                      rx_cnt_o
);

    localparam int PCKT_W = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W;
    localparam logic [PCKT_XADDR_W-1:0] NODE_X = PCKT_XADDR_W'(X_CORD);
    localparam logic [PCKT_YADDR_W-1:0] NODE_Y = PCKT_YADDR_W'(Y_CORD);

    logic [PCKT_W-1:0]       tx_wr_data;
    logic [PCKT_W-1:0]       tx_head;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    tx_push;
    logic                    tx_pop;

    logic [PCKT_XADDR_W-1:0] rx_x;
    logic [PCKT_YADDR_W-1:0] rx_y;
    logic                    rx_addr_ok;
    logic                    rx_full;
    logic                    rx_empty;
    logic                    rx_pop;
    logic                    rx_wr_req;
    logic                    rx_misroute;
    logic                    rx_overflow;

    // TX path
    assign tx_wr_data = {tx_dst_x_i, tx_dst_y_i, tx_data_i};
    assign tx_pop     = ~tx_empty & ~sw_full_i;
    assign tx_ready_o = ~tx_full | tx_pop;
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign sw_wr_en_o = tx_pop;
    assign sw_pckt_o  = tx_pop ? tx_head : '0;

    ni_sync_fifo #(
        .W       (PCKT_W),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_tx_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (tx_push),
        .wr_data_i (tx_wr_data),
        .rd_en_i   (tx_pop),
        .rd_data_o (tx_head),
        .full_o    (tx_full),
        .empty_o   (tx_empty)
    );

    // RX path: only the payload is stored, the address has already been checked
    assign rx_x        = sw_pckt_i[PCKT_W-1 -: PCKT_XADDR_W];
    assign rx_y        = sw_pckt_i[PCKT_DATA_W+PCKT_YADDR_W-1 -: PCKT_YADDR_W];
    assign rx_addr_ok  = (rx_x == NODE_X) && (rx_y == NODE_Y);
    assign rx_valid_o  = ~rx_empty;
    assign rx_pop      = rx_valid_o & rx_ready_i;
    assign rx_wr_req   = sw_wr_en_i & rx_addr_ok;
    assign rx_misroute = sw_wr_en_i & ~rx_addr_ok;
    assign rx_overflow = rx_wr_req & rx_full & ~rx_pop;
    assign rx_full_o   = rx_full;

    ni_sync_fifo #(
        .W       (PCKT_DATA_W),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_rx_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (rx_wr_req),
        .wr_data_i (sw_pckt_i[PCKT_DATA_W-1:0]),
        .rd_en_i   (rx_pop),
        .rd_data_o (rx_data_o),
        .full_o    (rx_full),
        .empty_o   (rx_empty)
    );

    // Sticky error flags and free-running packet counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o    <= '0;
            tx_cnt_o <= '0;
            rx_cnt_o <= '0;
        end else begin
            if (rx_misroute) begin
                err_o[ERR_MISROUTE_BIT] <= 1'b1;
            end
            if (rx_overflow) begin
                err_o[ERR_OVERFLOW_BIT] <= 1'b1;
            end
            if (tx_pop) begin
                tx_cnt_o <= tx_cnt_o + 1'b1;
            end
            if (rx_pop) begin
                rx_cnt_o <= rx_cnt_o + 1'b1;
            end
        end
    end

endmodule
